// File: rtl/time_buffer_pkg.sv
// Shared types and helpers for the multichannel time buffer.
package time_buffer_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      FILL,
      FULL
   } capture_state_t;

   typedef enum logic {
      IDLE,
      READ
   } replay_state_t;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tb_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module tb_sample_ram #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write the snapshot word and register the read word (1-cycle read latency).
   // NOTE: sample storage has no reset; contents are only meaningful after a complete capture.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/multichannel_time_buffer.sv
// Captures one multichannel A2D snapshot and replays it as overlapping batches
// (run-major, then channel, then sample) with a RAM stage, a 1-entry skid and an output register.
module multichannel_time_buffer
   import time_buffer_pkg::*;
#(
   parameter  int DATA_WIDTH = 14,
   parameter  int CHANNELS   = 2,
   parameter  int BATCH_SIZE = 2048,
   parameter  int RUNS       = 3,
   parameter  int STRIDE     = 1,
   localparam int TOT_SIZE   = BATCH_SIZE + (RUNS - 1) * STRIDE,
   localparam int AW         = safe_clog2(TOT_SIZE),
   localparam int CW         = safe_clog2(CHANNELS),
   localparam int RW         = safe_clog2(RUNS)
) (
   input  logic                           sink_clk,
   input  logic                           reset,
   input  logic                           arm,
   input  logic                           sink_valid,
   input  logic [CHANNELS*DATA_WIDTH-1:0] sink_data,
   output logic                           ready,
   input  logic                           start,
   output logic                           done,
   input  logic                           source_ready,
   output logic                           source_valid,
   output logic                           source_sop,
   output logic                           source_eop,
   output logic [CW-1:0]                  source_channel,
   output logic [RW-1:0]                  source_run,
   output logic [DATA_WIDTH-1:0]          source_data
);

   typedef struct packed {
      logic [CW-1:0] channel;
      logic [RW-1:0] run;
      logic          sop;
      logic          eop;
   } meta_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      meta_t                 m;
   } beat_t;

   capture_state_t cap_q, cap_d;
   replay_state_t  rep_q, rep_d;
   logic [AW-1:0]  wr_addr_q, wr_addr_d;
   logic [AW-1:0]  k_q, k_d, base_q, base_d;
   logic [CW-1:0]  ch_q, ch_d;
   logic [RW-1:0]  run_q, run_d;
   logic           pend_q, pend_d;

   logic  start_acc, arm_acc, wr_en, rd_en, last_issue, last_beat;
   logic  stalled, out_ready, room, skid_load;
   meta_t meta_d, ram_meta_q;
   beat_t ram_beat, skid_q, out_q;
   logic  ram_valid_q, skid_valid_q, out_valid_q;
   logic [CHANNELS*DATA_WIDTH-1:0] ram_rdata;

   // Handshake decisions: start wins over a simultaneous arm; arm needs replay idle.
   always_comb begin
      start_acc  = start & (cap_q == FULL) & (rep_q == IDLE);
      arm_acc    = arm & (rep_q == IDLE) & ~start_acc;
      wr_en      = (cap_q == FILL) & sink_valid & ~arm_acc;
      stalled    = out_valid_q & ~source_ready;
      out_ready  = ~stalled;
      // A new read may issue only if it can still be parked should the sink stall next cycle.
      room       = ~(stalled & skid_valid_q) & ~(stalled & ram_valid_q) & ~(skid_valid_q & ram_valid_q);
      rd_en      = start_acc | ((rep_q == READ) & pend_q & room);
      last_issue = (k_q == AW'(BATCH_SIZE - 1)) & (ch_q == CW'(CHANNELS - 1)) & (run_q == RW'(RUNS - 1));
      last_beat  = out_valid_q & source_ready & out_q.m.eop &
                   (out_q.m.channel == CW'(CHANNELS - 1)) & (out_q.m.run == RW'(RUNS - 1));
      skid_load  = ram_valid_q & (skid_valid_q ? out_ready : ~out_ready);
   end

   // State and counter registers, synchronous active-high reset.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sink_clk) begin
      if (reset) begin
         cap_q     <= EMPTY;
         rep_q     <= IDLE;
         wr_addr_q <= '0;
         k_q       <= '0;
         base_q    <= '0;
         ch_q      <= '0;
         run_q     <= '0;
         pend_q    <= 1'b0;
      end else begin
         cap_q     <= cap_d;
         rep_q     <= rep_d;
         wr_addr_q <= wr_addr_d;
         k_q       <= k_d;
         base_q    <= base_d;
         ch_q      <= ch_d;
         run_q     <= run_d;
         pend_q    <= pend_d;
      end
   end

   // Next-state logic for both FSMs and the read address generator.
   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cap_d     = cap_q;
      rep_d     = rep_q;
      wr_addr_d = wr_addr_q;
      k_d       = k_q;
      base_d    = base_q;
      ch_d      = ch_q;
      run_d     = run_q;
      pend_d    = pend_q;
      case (cap_q)
         EMPTY: if (arm_acc) begin cap_d = FILL; wr_addr_d = '0; end
         FILL: begin
            if (arm_acc) wr_addr_d = '0;
            else if (sink_valid) begin
               if (wr_addr_q == AW'(TOT_SIZE - 1)) begin cap_d = FULL; wr_addr_d = '0; end
               else wr_addr_d = wr_addr_q + AW'(1);
            end
         end
         FULL: if (arm_acc) begin cap_d = FILL; wr_addr_d = '0; end
         default: cap_d = EMPTY;
      endcase
      case (rep_q)
         IDLE:    if (start_acc) rep_d = READ;
         READ:    if (last_beat) rep_d = IDLE;
         default: rep_d = IDLE;
      endcase
      if (start_acc) pend_d = ~last_issue;
      else if (rd_en && last_issue) pend_d = 1'b0;
      if (rd_en) begin
         if (k_q == AW'(BATCH_SIZE - 1)) begin
            k_d = '0;
            if (ch_q == CW'(CHANNELS - 1)) begin
               ch_d = '0;
               if (run_q == RW'(RUNS - 1)) begin run_d = '0; base_d = '0; end
               else begin run_d = run_q + RW'(1); base_d = base_q + AW'(STRIDE); end
            end else ch_d = ch_q + CW'(1);
         end else k_d = k_q + AW'(1);
      end
   end

   // Sideband for the beat being read this cycle, plus channel select on the RAM word.
   always_comb begin
      meta_d.channel = ch_q;
      meta_d.run     = run_q;
      meta_d.sop     = (k_q == '0);
      meta_d.eop     = (k_q == AW'(BATCH_SIZE - 1));
      ram_beat.m     = ram_meta_q;
      ram_beat.data  = ram_rdata[ram_meta_q.channel * DATA_WIDTH +: DATA_WIDTH];
   end

   tb_sample_ram #(
      .DEPTH (TOT_SIZE),
      .AW    (AW),
      .WIDTH (CHANNELS * DATA_WIDTH)
   ) u_ram (
      .clk_i   (sink_clk),
      .we_i    (wr_en),
      .waddr_i (wr_addr_q),
      .wdata_i (sink_data),
      .re_i    (rd_en),
      .raddr_i (base_q + k_q),
      .rdata_o (ram_rdata)
   );

   // Payload registers that need no reset: sideband of the in-flight read and skid contents.
   always_ff @(posedge sink_clk) begin
      if (rd_en)     ram_meta_q <= meta_d;
      if (skid_load) skid_q     <= ram_beat;
   end

   // Read pipeline occupancy and the output register; drained oldest-first (out, skid, RAM).
   always_ff @(posedge sink_clk) begin
      if (reset) begin
         ram_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_q        <= '0;
      end else begin
         ram_valid_q <= rd_en;
         if (out_ready) begin
            if (skid_valid_q) begin
               out_q        <= skid_q;
               out_valid_q  <= 1'b1;
               skid_valid_q <= ram_valid_q;
            end else if (ram_valid_q) begin
               out_q       <= ram_beat;
               out_valid_q <= 1'b1;
            end else out_valid_q <= 1'b0;
         end else if (ram_valid_q) skid_valid_q <= 1'b1;
      end
   end

   // Status and source outputs decoded from state and the output register.
   always_comb begin
      ready          = (cap_q == FULL);
      done           = (rep_q == IDLE);
      source_valid   = out_valid_q;
      source_sop     = out_q.m.sop;
      source_eop     = out_q.m.eop;
      source_channel = out_q.m.channel;
      source_run     = out_q.m.run;
      source_data    = out_q.data;
   end

endmodule

// File: tb/tb_multichannel_time_buffer.sv
// Directed bench for multichannel_time_buffer: 2 channels, 4-sample batches, 3 runs, stride 2.
module tb_multichannel_time_buffer;

   localparam int DW = 8;
   localparam int CH = 2;
   localparam int BS = 4;
   localparam int RN = 3;
   localparam int ST = 2;
   localparam int NBEATS = RN * CH * BS;

   typedef struct {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       ch;
      logic [1:0] run;
   } vec_t;

   logic        sink_clk = 1'b0;
   logic        reset, arm, sink_valid, start, source_ready;
   logic [15:0] sink_data;
   logic        ready, done, source_valid, source_sop, source_eop;
   logic        source_channel;
   logic [1:0]  source_run;
   logic [7:0]  source_data;

   int   total = 0;
   int   bad   = 0;
   vec_t exp_tbl [NBEATS];

   always #5 sink_clk = ~sink_clk;

   multichannel_time_buffer #(
      .DATA_WIDTH (DW),
      .CHANNELS   (CH),
      .BATCH_SIZE (BS),
      .RUNS       (RN),
      .STRIDE     (ST)
   ) dut (
      .sink_clk       (sink_clk),
      .reset          (reset),
      .arm            (arm),
      .sink_valid     (sink_valid),
      .sink_data      (sink_data),
      .ready          (ready),
      .start          (start),
      .done           (done),
      .source_ready   (source_ready),
      .source_valid   (source_valid),
      .source_sop     (source_sop),
      .source_eop     (source_eop),
      .source_channel (source_channel),
      .source_run     (source_run),
      .source_data    (source_data)
   );

   task automatic tick();
      @(posedge sink_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Compare the visible beat {valid,sop,eop,channel,run,data} against table entry idx.
   task automatic check_beat(input string name, input int idx);
      logic [31:0] act, req;
      act = {18'd0, source_valid, source_sop, source_eop, source_channel, source_run, source_data};
      req = {18'd0, 1'b1, exp_tbl[idx].sop, exp_tbl[idx].eop, exp_tbl[idx].ch,
             exp_tbl[idx].run, exp_tbl[idx].data};
      check($sformatf("%s[%0d]", name, idx), act, req);
   endtask

   // Arm, then write the 8-sample ramp; gaps inserts an idle cycle after each valid sample.
   task automatic do_fill(input bit gaps);
      logic [7:0] d0, d1;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check("arm_ready_low", {31'd0, ready}, 32'd0);
      for (int n = 0; n < 8; n++) begin
         d0 = 8'(n);
         d1 = 8'(128 + n);
         sink_valid = 1'b1;
         sink_data  = {d1, d0};
         tick();
         sink_valid = 1'b0;
         if (n < 7) check("fill_ready_low", {31'd0, ready}, 32'd0);
         else       check("fill_ready_set", {31'd0, ready}, 32'd1);
         if (gaps && n < 7) tick();
      end
      check("fill_done_high", {31'd0, done}, 32'd1);
   endtask

   // Start a replay and check all beats; optional stall, arm pulse, start+arm, or reset abort.
   task automatic do_replay(input int stall_at, input int arm_at, input int abort_at, input bit with_arm);
      int idx, stalls, cyc;
      start = 1'b1;
      arm   = with_arm;
      tick();
      start = 1'b0;
      arm   = 1'b0;
      check("start_done_low", {31'd0, done}, 32'd0);
      check("start_valid_low", {31'd0, source_valid}, 32'd0);
      tick();
      idx = 0; stalls = 0; cyc = 0;
      while (idx < NBEATS && cyc < 200) begin
         cyc++;
         if (idx == abort_at) begin
            reset = 1'b1;
            tick();
            check("abort_valid", {31'd0, source_valid}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd1);
            check("abort_ready", {31'd0, ready}, 32'd0);
            reset = 1'b0;
            tick();
            return;
         end
         check_beat("beat", idx);
         source_ready = !(idx == stall_at && stalls < 3);
         if (!source_ready) stalls++;
         arm = (idx == arm_at);
         tick();
         if (source_ready) idx++;
      end
      arm = 1'b0;
      source_ready = 1'b1;
      check("replay_count", 32'(idx), 32'(NBEATS));
      check("replay_done", {31'd0, done}, 32'd1);
      check("replay_valid_low", {31'd0, source_valid}, 32'd0);
   endtask

   initial begin
      // Expected replay order: run r, channel c, sample k reads address r*STRIDE+k.
      begin
         int i;
         i = 0;
         for (int r = 0; r < RN; r++)
            for (int c = 0; c < CH; c++)
               for (int k = 0; k < BS; k++) begin
                  exp_tbl[i].data = 8'((c == 1 ? 128 : 0) + r * ST + k);
                  exp_tbl[i].sop  = (k == 0);
                  exp_tbl[i].eop  = (k == BS - 1);
                  exp_tbl[i].ch   = 1'(c);
                  exp_tbl[i].run  = 2'(r);
                  i++;
               end
      end

      reset = 1'b1; arm = 1'b0; sink_valid = 1'b0; sink_data = '0;
      start = 1'b0; source_ready = 1'b1;
      tick();
      tick();
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd1);
      check("rst_beat", {21'd0, source_valid, source_sop, source_eop, source_channel,
                         source_run, source_data}, 32'd0);
      reset = 1'b0;
      tick();

      // start without a snapshot is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      check("early_start_done", {31'd0, done}, 32'd1);
      tick();
      check("early_start_valid", {31'd0, source_valid}, 32'd0);

      do_fill(1'b0);
      do_replay(-1, -1, -1, 1'b0);

      // stall on beat 3 (eop of r0c0) and an arm pulse while busy
      do_replay(3, 5, -1, 1'b0);
      check("arm_busy_ignored", {31'd0, ready}, 32'd1);

      // start and arm together: replay proceeds, snapshot kept
      do_replay(-1, -1, -1, 1'b1);
      check("start_beats_arm", {31'd0, ready}, 32'd1);

      // gapped capture of the same ramp gives the same replay
      do_fill(1'b1);
      do_replay(-1, -1, -1, 1'b0);

      // reset in the middle of replay
      do_replay(-1, -1, 10, 1'b0);
      check("post_abort_valid", {31'd0, source_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
